// File: rtl/nv_rst_release_seq.sv
// nv_rst_release_seq: staged reset release sequencer with software re-reset and DFT bypass
module nv_rst_release_seq #(
  parameter int NUM_STAGES  = 4,
  parameter int GAP_W       = 8,
  parameter int SW_HOLD_CYC = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  sw_rst_req,
  input  logic [GAP_W-1:0]      gap_cycles,
  input  logic                  test_mode,
  output logic [NUM_STAGES-1:0] stage_rstn,
  output logic                  seq_busy,
  output logic                  seq_done
);
  localparam int IW = $clog2(NUM_STAGES);
  localparam int HW = $clog2(SW_HOLD_CYC + 1);
  localparam int CW = GAP_W > HW ? GAP_W : HW;
  localparam logic [IW-1:0] LAST = IW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(SW_HOLD_CYC - 1);
  typedef enum logic [2:0] {HOLD, WAIT, RUN, DRAIN, SWHOLD} state_t;
  state_t st, st_n;
  logic [2:0] sync;
  logic [NUM_STAGES-1:0] stg, stg_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n, gap;
  logic busy_n, done_n, go;
  assign gap = CW'(gap_cycles);
  // sync[2] is rstn_sync; its d-input lets stage 0 release on the same edge rstn_sync rises
  assign go = sync[1] | sync[2];
  assign stage_rstn = test_mode ? {NUM_STAGES{nvdla_core_rstn}} : stg;
  // reset synchronizer: async assert, release after three edges
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) sync <= '0;
    else sync <= {sync[1:0], 1'b1};
  // sequencer state and registered outputs
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      st       <= HOLD;
      stg      <= '0;
      idx      <= '0;
      cnt      <= '0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      st       <= st_n;
      stg      <= stg_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      seq_busy <= busy_n;
      seq_done <= done_n;
    end
  // next state: ascending release with gaps, descending drain, hold, re-release
  always_comb begin
    st_n   = st;
    stg_n  = stg;
    idx_n  = idx;
    cnt_n  = cnt;
    busy_n = seq_busy;
    done_n = seq_done;
    case (st)
      HOLD: if (go) begin
        stg_n[0] = 1'b1;
        idx_n    = '0;
        cnt_n    = gap;
        busy_n   = 1'b1;
        st_n     = WAIT;
      end
      WAIT: if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (idx != LAST) begin
          idx_n        = idx + 1'b1;
          stg_n[idx_n] = 1'b1;
          cnt_n        = gap;
        end else begin
          busy_n = 1'b0;
          done_n = 1'b1;
          st_n   = RUN;
        end
      RUN: if (sw_rst_req) begin
        stg_n[NUM_STAGES-1] = 1'b0;
        idx_n  = LAST;
        done_n = 1'b0;
        busy_n = 1'b1;
        st_n   = DRAIN;
      end
      DRAIN: begin
        idx_n        = idx - 1'b1;
        stg_n[idx_n] = 1'b0;
        if (idx == IW'(1)) begin
          cnt_n = HOLD_LD;
          st_n  = SWHOLD;
        end
      end
      SWHOLD: if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          stg_n[0] = 1'b1;
          cnt_n    = gap;
          st_n     = WAIT;
        end
      default: st_n = HOLD;
    endcase
  end
endmodule

// File: tb/tb_nv_rst_release_seq.sv
// tb_nv_rst_release_seq: directed checks of staged release, drain, async reset and test bypass
`timescale 1ns/1ps
module tb_nv_rst_release_seq;
  logic clk = 1'b0;
  logic rstn, sw = 1'b0, tm = 1'b0;
  logic [7:0] gap = 8'd2;
  logic [3:0] stage;
  logic busy, done;
  int n_chk = 0, n_err = 0;
  always #10 clk = ~clk;
  nv_rst_release_seq #(.NUM_STAGES(4), .GAP_W(8), .SW_HOLD_CYC(16)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .sw_rst_req(sw), .gap_cycles(gap),
    .test_mode(tm), .stage_rstn(stage), .seq_busy(busy), .seq_done(done));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // stage k releases at edge s0+k*(g+1); done at s0+4*(g+1); optional ignored request at edge pe
  task automatic rel(input int s0, input int g, input int pe, input string tag);
    int d, nrel;
    d = s0 + 4 * (g + 1);
    for (int e = 1; e <= d + 1; e++) begin
      if (e == pe) sw = 1'b1;
      tick();
      sw = 1'b0;
      nrel = (e < s0) ? 0 : ((e - s0) / (g + 1) + 1);
      if (nrel > 4) nrel = 4;
      check({tag, "_stage"}, 32'(stage), 32'((1 << nrel) - 1));
      check({tag, "_busy"}, 32'(busy), 32'(e >= s0 && e < d));
      check({tag, "_done"}, 32'(done), 32'(e >= d));
    end
  endtask
  always @(negedge clk) check("thermo", 32'(stage & (stage + 4'd1)), 32'd0);
  initial begin
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    rel(3, 2, 7, "pon");
    sw = 1'b1;
    tick();
    sw = 1'b0;
    check("drn0_stage", 32'(stage), 32'h7);
    check("drn0_done", 32'(done), 32'd0);
    check("drn0_busy", 32'(busy), 32'd1);
    sw = 1'b1;
    tick();
    sw = 1'b0;
    check("drn1_stage", 32'(stage), 32'h3);
    tick();
    check("drn2_stage", 32'(stage), 32'h1);
    tick();
    check("drn3_stage", 32'(stage), 32'h0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) sw = 1'b1;
      tick();
      sw = 1'b0;
      check("hold_stage", 32'(stage), 32'h0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    rel(1, 2, 0, "swrel");
    rstn = 1'b0;
    #1;
    check("rst2_done", 32'(done), 32'd0);
    tick();
    rstn = 1'b1;
    for (int e = 1; e <= 6; e++) tick();
    check("mid_stage", 32'(stage), 32'h3);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async_stage", 32'(stage), 32'h0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    tick();
    rstn = 1'b1;
    rel(3, 2, 0, "rep");
    rstn = 1'b0;
    tick();
    gap = 8'd0;
    rstn = 1'b1;
    rel(3, 0, 0, "g0");
    tick();
    tm = 1'b1;
    #1;
    check("tm_hi", 32'(stage), 32'hf);
    rstn = 1'b0;
    #1;
    check("tm_lo", 32'(stage), 32'h0);
    check("tm_busy", 32'(busy), 32'd0);
    check("tm_done", 32'(done), 32'd0);
    rstn = 1'b1;
    #1;
    check("tm_hi2", 32'(stage), 32'hf);
    tm = 1'b0;
    #1;
    check("tm_off", 32'(stage), 32'h0);
    rel(3, 0, 0, "tmrel");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
